// File: rtl/cnt_timer_arb_pkg.sv
// Shared definitions for the round-robin timer arbiter: FSM encodings and
// the rotating first-set search used to pick the next requester.
package cnt_timer_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam int MAX_N = 8;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } rr_pick_t;

    // Walk offsets from high to low so the smallest offset from ptr is the last writer.
    function automatic rr_pick_t rr_first(input logic [MAX_N-1:0] req,
                                          input logic [2:0]       ptr,
                                          input int               n);
        rr_pick_t p;
        int       j;
        p = '0;
        for (int k = MAX_N - 1; k >= 0; k--) begin
            if (k < n) begin
                j = (int'(ptr) + k) % n;
                if (req[j]) begin
                    p.hit = 1'b1;
                    p.idx = 3'(j);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/cnt_timer_arb_if.sv
// Request/grant bundle between N timed-interval requesters and the shared timer.
// Requesters hold req until done; gnt/done/busy/q are registered in the arbiter.
interface cnt_timer_arb_if #(
    parameter int N    = 4,
    parameter int Bits = 8
);
    logic [N-1:0]      req;
    logic [N*Bits-1:0] len;
    logic [N-1:0]      gnt;
    logic [N-1:0]      done;
    logic              busy;
    logic [Bits-1:0]   q;

    modport master (output req, len, input gnt, done, busy, q);
    modport slave  (input req, len, output gnt, done, busy, q);
endinterface

// File: rtl/cnt_timer_arb_cnt_ce.sv
// Up-counter with async clear, synchronous clear and count enable; q updates one edge
// after ce. No backpressure: sclr wins over ce.
module cnt_ce #(
    parameter int Bits = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_sclr,
    input  logic            i_ce,
    output logic [Bits-1:0] o_q
);
    logic [Bits-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)       r_q <= '0;
        else if (i_sclr) r_q <= '0;
        else if (i_ce)   r_q <= r_q + 1'b1;
    end

    assign o_q = r_q;
endmodule

// File: rtl/cnt_timer_arb.sv
// Round-robin arbiter lending one up-counter to N requesters; grant lasts len+1 cycles,
// then a one-cycle done and one dead cycle. Losers simply wait with req held.
module cnt_timer_arb
    import cnt_timer_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int Bits = 8
) (
    input  logic         i_clk,
    input  logic         i_clr,
    cnt_timer_arb_if.slave s_if
);
    localparam int IW = $clog2(N);

    logic [1:0]      r_state;
    logic [1:0]      w_state_n;
    logic [N-1:0]    r_gnt,  w_gnt_n;
    logic [N-1:0]    r_done, w_done_n;
    logic            r_busy, w_busy_n;
    logic [Bits-1:0] r_len,  w_len_n;
    logic [IW-1:0]   r_gidx, w_gidx_n;
    logic [IW-1:0]   r_ptr,  w_ptr_n;
    logic            w_sclr, w_ce;
    logic [Bits-1:0] w_q;

    logic [MAX_N-1:0] w_req8;
    logic [2:0]       w_ptr3;
    rr_pick_t         w_pick;
    logic             w_g_req;
    logic             w_reached;
    logic [IW-1:0]    w_ptr_adv;

    always_comb begin
        w_req8         = '0;
        w_req8[N-1:0]  = s_if.req;
        w_ptr3         = '0;
        w_ptr3[IW-1:0] = r_ptr;
    end

    assign w_pick    = rr_first(w_req8, w_ptr3, N);
    assign w_g_req   = s_if.req[r_gidx];
    assign w_reached = (w_q == r_len);
    assign w_ptr_adv = (r_gidx == IW'(N - 1)) ? '0 : r_gidx + 1'b1;

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_len   <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_n;
            r_gnt   <= w_gnt_n;
            r_done  <= w_done_n;
            r_busy  <= w_busy_n;
            r_len   <= w_len_n;
            r_gidx  <= w_gidx_n;
            r_ptr   <= w_ptr_n;
        end
    end

    // Abort is tested before completion so a dropped request never gets a done.
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE: if (w_pick.hit) w_state_n = ST_RUN;
            ST_RUN: begin
                if (!w_g_req)       w_state_n = ST_IDLE;
                else if (w_reached) w_state_n = ST_FIN;
            end
            ST_FIN:  w_state_n = ST_IDLE;
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        w_gnt_n  = r_gnt;
        w_done_n = '0;
        w_busy_n = r_busy;
        w_len_n  = r_len;
        w_gidx_n = r_gidx;
        w_ptr_n  = r_ptr;
        w_sclr   = 1'b0;
        w_ce     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick.hit) begin
                    w_gnt_n                    = '0;
                    w_gnt_n[w_pick.idx[IW-1:0]] = 1'b1;
                    w_len_n  = s_if.len[int'(w_pick.idx) * Bits +: Bits];
                    w_gidx_n = w_pick.idx[IW-1:0];
                    w_busy_n = 1'b1;
                    w_sclr   = 1'b1;
                end
            end
            ST_RUN: begin
                if (!w_g_req || w_reached) begin
                    w_gnt_n  = '0;
                    w_busy_n = 1'b0;
                    w_sclr   = 1'b1;
                    w_ptr_n  = w_ptr_adv;
                    if (w_g_req) w_done_n = r_gnt;
                end else begin
                    w_ce = 1'b1;
                end
            end
            default: begin
                w_gnt_n  = '0;
                w_busy_n = 1'b0;
            end
        endcase
    end

    cnt_ce #(.Bits(Bits)) u_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_clr),
        .i_sclr (w_sclr),
        .i_ce   (w_ce),
        .o_q    (w_q)
    );

    assign s_if.gnt  = r_gnt;
    assign s_if.done = r_done;
    assign s_if.busy = r_busy;
    assign s_if.q    = w_q;
endmodule

// File: tb/tb_cnt_timer_arb.sv
// Directed bench for cnt_timer_arb: single/zero/max length, round-robin order,
// abort, and asynchronous clear during a run.
module tb_cnt_timer_arb;
    localparam int N    = 4;
    localparam int Bits = 8;

    logic clk;
    logic clr;
    int   n_tests;
    int   n_fail;

    cnt_timer_arb_if #(.N(N), .Bits(Bits)) bus ();

    cnt_timer_arb #(.N(N), .Bits(Bits)) dut (
        .i_clk (clk),
        .i_clr (clr),
        .s_if  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input int v);
        bus.len[i*Bits +: Bits] = Bits'(v);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        #2;
        chk("clr_gnt",  32'(bus.gnt),  0);
        chk("clr_busy", 32'(bus.busy), 0);
        chk("clr_q",    32'(bus.q),    0);
        clr = 1'b0;
    endtask

    initial begin
        int cnt;
        int lastq;
        logic [N-1:0] oh;
        int order [5];
        order = '{0, 1, 2, 3, 0};
        n_tests = 0;
        n_fail  = 0;
        clr     = 1'b1;
        bus.req = '0;
        bus.len = '0;
        #1;
        chk("rst_gnt",  32'(bus.gnt),  0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_q",    32'(bus.q),    0);
        #11;
        clr = 1'b0;

        // Single request, length 3
        set_len(0, 3);
        bus.req = 4'b0001;
        tick();
        chk("t1_gnt",  32'(bus.gnt),  32'b0001);
        chk("t1_busy", 32'(bus.busy), 1);
        chk("t1_q0",   32'(bus.q),    0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("t1_gnt_run", 32'(bus.gnt), 32'b0001);
            chk("t1_q",       32'(bus.q),   32'(k));
        end
        tick();
        chk("t1_done",      32'(bus.done), 32'b0001);
        chk("t1_gnt_off",   32'(bus.gnt),  0);
        chk("t1_busy_off",  32'(bus.busy), 0);
        chk("t1_q_off",     32'(bus.q),    0);
        bus.req = '0;
        tick();
        chk("t1_done_1cyc", 32'(bus.done), 0);
        chk("t1_idle_gnt",  32'(bus.gnt),  0);

        // Zero length
        set_len(1, 0);
        bus.req = 4'b0010;
        tick();
        chk("t2_gnt", 32'(bus.gnt), 32'b0010);
        chk("t2_q",   32'(bus.q),   0);
        tick();
        chk("t2_done", 32'(bus.done), 32'b0010);
        chk("t2_gnt_off", 32'(bus.gnt), 0);
        bus.req = '0;
        tick();
        chk("t2_done_off", 32'(bus.done), 0);

        // Round-robin with all requests held, ptr reset to 0
        pulse_clr();
        for (int i = 0; i < N; i++) set_len(i, 1);
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            oh = '0;
            oh[order[g]] = 1'b1;
            tick();
            chk("t3_gnt_a", 32'(bus.gnt), 32'(oh));
            chk("t3_q_a",   32'(bus.q),   0);
            tick();
            chk("t3_gnt_b", 32'(bus.gnt), 32'(oh));
            chk("t3_q_b",   32'(bus.q),   1);
            tick();
            chk("t3_done",  32'(bus.done), 32'(oh));
            chk("t3_gnt_f", 32'(bus.gnt),  0);
            tick();
            chk("t3_idle_gnt",  32'(bus.gnt),  0);
            chk("t3_idle_done", 32'(bus.done), 0);
        end
        bus.req = '0;
        tick();

        // Abort: ptr is 1, so req[2] beats pending req[0]
        set_len(2, 10);
        set_len(0, 1);
        bus.req = 4'b0101;
        tick();
        chk("t4_gnt", 32'(bus.gnt), 32'b0100);
        for (int k = 1; k <= 4; k++) tick();
        chk("t4_q4", 32'(bus.q), 4);
        bus.req = 4'b0001;
        tick();
        chk("t4_abort_gnt",  32'(bus.gnt),  0);
        chk("t4_abort_done", 32'(bus.done), 0);
        chk("t4_abort_busy", 32'(bus.busy), 0);
        chk("t4_abort_q",    32'(bus.q),    0);
        tick();
        chk("t4_wrap_gnt", 32'(bus.gnt), 32'b0001);
        chk("t4_no_done",  32'(bus.done), 0);

        // Asynchronous clear mid-run
        bus.req = '0;
        pulse_clr();
        set_len(0, 200);
        bus.req = 4'b0001;
        tick();
        for (int k = 0; k < 50; k++) tick();
        chk("t5_q50", 32'(bus.q), 50);
        #2;
        clr = 1'b1;
        #1;
        chk("t5_async_gnt",  32'(bus.gnt),  0);
        chk("t5_async_busy", 32'(bus.busy), 0);
        chk("t5_async_q",    32'(bus.q),    0);
        chk("t5_async_done", 32'(bus.done), 0);
        for (int i = 0; i < N; i++) set_len(i, 2);
        bus.req = 4'b1111;
        clr = 1'b0;
        tick();
        chk("t5_first_gnt", 32'(bus.gnt), 32'b0001);

        // Max length, with LEN changed after the grant edge
        bus.req = '0;
        pulse_clr();
        set_len(3, 255);
        bus.req = 4'b1000;
        tick();
        set_len(3, 5);
        cnt   = 0;
        lastq = -1;
        while (bus.gnt == 4'b1000 && cnt < 300) begin
            lastq = int'(bus.q);
            cnt++;
            tick();
        end
        chk("t6_gnt_cycles", 32'(cnt),      256);
        chk("t6_last_q",     32'(lastq),    255);
        chk("t6_done",       32'(bus.done), 32'b1000);
        chk("t6_q_after",    32'(bus.q),    0);
        bus.req = '0;
        tick();
        chk("t6_done_off", 32'(bus.done), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cnt_timer_arb.md
Name: cnt_timer_arb

Overview:
- Round-robin arbiter and sequencer for one shared up-counter timer.
- Up to N requesters each ask for a timed interval of programmable length.
- The block grants the counter to one requester at a time and runs it for that length.
- It then pulses a per-requester DONE, and moves on to the next requester in round-robin order.
- Used wherever several control paths need timed delays but only one counter resource is allocated.

Parameters:
- N, 4, number of requesters (2..8)
- Bits, 8, counter and length width

Ports:
- CLK  in  1  system clock; all state changes on the rising edge
- CLR  in  1  reset, asynchronous, active-high; clears all state immediately
- REQ  in  N  per-requester request level; held high until DONE or abandoned
- LEN  in  N*Bits  per-requester interval length; slice i = LEN[i*Bits +: Bits]
- GNT  out  N  one-hot grant; all zero when idle
- DONE  out  N  one-cycle completion pulse to the granted requester
- BUSY  out  1  high while a grant is active (state RUN)
- Q  out  Bits  live counter value; 0 when not running

Behaviour:
- Reset (CLR=1, async): state=IDLE, GNT=0, DONE=0, BUSY=0, Q=0, rr pointer=0, latched length=0.
- FSM states:
  - IDLE -> RUN: any REQ bit is high at a clock edge.
  - RUN -> FIN: the counter has reached the latched length.
  - RUN -> IDLE: abort, when REQ of the granted requester drops.
  - FIN -> IDLE: always, after one cycle.
- Arbitration in IDLE:
  - Search REQ starting at index ptr, wrapping modulo N; the first set bit wins (index g).
  - On that edge: GNT <= onehot(g), len_r <= LEN slice g, Q <= 0, BUSY <= 1.
- RUN:
  - Q increments by 1 each edge while Q != len_r.
  - When Q == len_r at an edge: state <= FIN, DONE[g] <= 1, GNT <= 0, BUSY <= 0, Q <= 0, ptr <= (g+1) mod N.
  - GNT is therefore high for exactly len_r+1 cycles. LEN=0 gives 1 cycle of grant; LEN=2^Bits-1 gives 2^Bits cycles. The counter never wraps.
- FIN:
  - DONE high for exactly one cycle.
  - Next state is IDLE unconditionally, so there is one dead cycle between consecutive grants.
  - New arbitration happens in the following IDLE cycle.
- Abort: REQ[g] low at an edge while in RUN.
  - state <= IDLE, GNT <= 0, BUSY <= 0, Q <= 0, no DONE, ptr <= (g+1) mod N.
  - Abort takes priority over completion if both occur at the same edge.
- Timing of inputs:
  - LEN changes after the grant edge are ignored.
  - REQ changes of non-granted requesters during RUN or FIN have no effect.
- Simultaneous requests: resolved purely by round-robin from ptr. No requester waits more than N-1 grants.
- CLR asserted mid-RUN: outputs clear asynchronously, no DONE is issued, ptr returns to 0.
- All outputs are registered; no combinational path from REQ/LEN to outputs.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_FIN=2'd2
  - function for the round-robin first-set search
- One natural sub-module: cnt_ce.
  - Bits-wide up-counter with async active-high clear, synchronous clear and count enable.
  - Instantiated once to produce Q.
- The arbiter/FSM stays in the top module.

Test Plan:
1. Single request: REQ=4'b0001, LEN0=3 -> GNT=0001 for 4 cycles with Q=0,1,2,3; DONE=0001 one cycle; then IDLE, BUSY=0, Q=0.
2. Zero length: REQ=0010, LEN1=0 -> GNT=0010 for 1 cycle, Q=0, then DONE=0010 pulse.
3. Round-robin fairness: REQ=1111 held, all LEN=1, after reset -> grant order 0,1,2,3,0. Each grant is 2 cycles, followed by 1 DONE cycle and 1 idle cycle.
4. Abort: REQ=0100, LEN2=10; drop REQ[2] when Q=4 -> GNT clears on the next edge, no DONE, ptr=3. A pending REQ[0] is then granted (search wraps from 3).
5. Async reset mid-run: LEN=200, assert CLR at Q=50 between edges -> GNT, BUSY and Q go to 0 without waiting for an edge. After release, with REQ=1111, index 0 is granted first.
6. Max length: Bits=8, LEN=255 -> GNT high 256 cycles, Q ends at 255 with no wrap, then DONE pulse.
